// File: rtl/potential_decay_array.sv
// Per-neuron FP32 potential table, swept once per timestep: each entry is decayed by 2^-k or 0.75 and written back.
// Optional feature macro: POTENTIAL_DECAY_UNDERFLOW_CNT_EN adds the 16-bit underflow_count output.
module potential_decay_array #(
  parameter int          NUM_NEURONS     = 32,
  parameter int          ADDR_W          = 5,
  parameter logic [31:0] RESET_POTENTIAL = 32'h41DED852
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [31:0]       init_potential,
  input  logic [3:0]        init_rate,
  input  logic              timestep_start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic              busy,
  output logic              done
`ifdef POTENTIAL_DECAY_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_count
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, EMIT, DONE} state_t;

  localparam logic [ADDR_W:0]   LP_NUM  = (ADDR_W+1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_NEURONS-1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_pot  [NUM_NEURONS];
  logic [3:0]        r_rate [NUM_NEURONS];
  logic [31:0]       r_ld_pot;
  logic [3:0]        r_ld_rate;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [31:0]       r_out_potential;
  logic              r_busy;
  logic              r_done;
  logic              r_flush;
`ifdef POTENTIAL_DECAY_UNDERFLOW_CNT_EN
  logic [15:0]       r_underflow_count;
`endif

  logic w_init_ok;
  logic w_wb;

  assign w_init_ok = (r_state == IDLE) && init_we && ({1'b0, init_addr} < LP_NUM);
  assign w_wb      = (r_state == EMIT) && out_ready;

  // Neuron table: host writes only while idle, sweep writes back on each handshake.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_pot[i]  <= RESET_POTENTIAL;
        r_rate[i] <= 4'b0001;
      end
    end else if (w_init_ok) begin
      r_pot[init_addr]  <= init_potential;
      r_rate[init_addr] <= init_rate;
    end else if (w_wb) begin
      r_pot[r_idx] <= r_out_potential;
    end
  end

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic [23:0] w_sig;
  logic [24:0] w_sum;
  logic [1:0]  w_k;
  logic        w_is_75;
  logic [31:0] w_dec;
  logic        w_flush;

  always_comb begin
    w_sign  = r_ld_pot[31];
    w_exp   = r_ld_pot[30:23];
    w_man   = r_ld_pot[22:0];
    w_sig   = {1'b1, w_man};
    w_sum   = {1'b0, w_sig} + {2'b00, w_sig[23:1]};
    w_is_75 = (r_ld_rate == 4'b0011);
    case (r_ld_rate)
      4'b0010: w_k = 2'd1;
      4'b0100: w_k = 2'd2;
      4'b1000: w_k = 2'd3;
      default: w_k = 2'd0;
    endcase
    w_dec   = r_ld_pot;
    w_flush = 1'b0;
    if (w_exp == 8'hFF) begin
      w_dec = r_ld_pot;
    end else if (w_exp == 8'd0) begin
      w_dec = {w_sign, 31'b0};
    end else if (w_is_75) begin
      // sum = 1.5 * significand; result is sum/2, renormalised when sum reaches 2.0
      if (w_exp <= 8'd1) begin
        w_dec   = {w_sign, 31'b0};
        w_flush = 1'b1;
      end else if (w_sum[24]) begin
        w_dec = {w_sign, w_exp, w_sum[23:1]};
      end else begin
        w_dec = {w_sign, w_exp - 8'd1, w_sum[22:0]};
      end
    end else if (w_k != 2'd0) begin
      if (w_exp <= {6'b0, w_k}) begin
        w_dec   = {w_sign, 31'b0};
        w_flush = 1'b1;
      end else begin
        w_dec = {w_sign, w_exp - {6'b0, w_k}, w_man};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_ld_pot        <= '0;
      r_ld_rate       <= '0;
      r_out_valid     <= 1'b0;
      r_out_addr      <= '0;
      r_out_potential <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_flush         <= 1'b0;
`ifdef POTENTIAL_DECAY_UNDERFLOW_CNT_EN
      r_underflow_count <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (timestep_start) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
`ifdef POTENTIAL_DECAY_UNDERFLOW_CNT_EN
            r_underflow_count <= '0;
`endif
          end
        end
        LOAD: begin
          r_ld_pot  <= r_pot[r_idx];
          r_ld_rate <= r_rate[r_idx];
          r_state   <= COMPUTE;
        end
        COMPUTE: begin
          r_out_potential <= w_dec;
          r_out_addr      <= r_idx;
          r_out_valid     <= 1'b1;
          r_flush         <= w_flush;
          r_state         <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
`ifdef POTENTIAL_DECAY_UNDERFLOW_CNT_EN
            if (r_flush && (r_underflow_count != 16'hFFFF))
              r_underflow_count <= r_underflow_count + 16'd1;
`endif
            if (r_idx == LP_LAST) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= LOAD;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid     = r_out_valid;
  assign out_addr      = r_out_addr;
  assign out_potential = r_out_potential;
  assign busy          = r_busy;
  assign done          = r_done;
`ifdef POTENTIAL_DECAY_UNDERFLOW_CNT_EN
  assign underflow_count = r_underflow_count;
`endif

endmodule

// File: doc/potential_decay_array.md
POTENTIAL_DECAY_ARRAY -- requirements
Module: potential_decay_array

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_NEURONS SHALL default to 32 and set the number of neurons held.
REQ-003 Parameter ADDR_W SHALL default to 5 and set the neuron address width, with 2^ADDR_W >= NUM_NEURONS.
REQ-004 Parameter RESET_POTENTIAL SHALL default to 32'h41DED852 and set the reset value of every potential.
REQ-005 Port CLK SHALL be an input, 1 bit wide, carrying the clock.
REQ-006 Port reset SHALL be an input, 1 bit wide, carrying the synchronous active-high reset.
REQ-007 Port init_we SHALL be an input, 1 bit wide, carrying the neuron table write strobe.
REQ-008 Port init_addr SHALL be an input, ADDR_W bits wide, carrying the table write address.
REQ-009 Port init_potential SHALL be an input, 32 bits wide, carrying an IEEE-754 single-precision potential.
REQ-010 Port init_rate SHALL be an input, 4 bits wide, carrying the per-neuron decay code.
REQ-011 Port timestep_start SHALL be an input, 1 bit wide, carrying the sweep request pulse.
REQ-012 Port out_ready SHALL be an input, 1 bit wide, carrying consumer ready.
REQ-013 Port out_valid SHALL be an output, 1 bit wide, marking a decayed potential as present.
REQ-014 Port out_addr SHALL be an output, ADDR_W bits wide, carrying the neuron index of the output.
REQ-015 Port out_potential SHALL be an output, 32 bits wide, carrying the decayed potential.
REQ-016 Port busy SHALL be an output, 1 bit wide, and be high whenever the FSM is not in IDLE.
REQ-017 Port done SHALL be an output, 1 bit wide, giving a one-cycle pulse at the end of a sweep.

Function
REQ-018 The block SHALL hold NUM_NEURONS registered entries, each a 32-bit potential plus a 4-bit rate.
REQ-019 The FSM SHALL have the states IDLE, LOAD, COMPUTE, EMIT and DONE.
REQ-020 In IDLE, timestep_start SHALL set the neuron index to 0 and move the FSM to LOAD.
REQ-021 A timestep_start received outside IDLE SHALL be ignored.
REQ-022 LOAD SHALL register the entry at the current index; COMPUTE SHALL register the decay result and assert out_valid.
REQ-023 EMIT SHALL hold out_valid, out_addr and out_potential stable until out_valid and out_ready are both high.
REQ-024 On the EMIT handshake the result SHALL be written back to the entry; the FSM SHALL then move to LOAD for the next index, or to DONE after index NUM_NEURONS-1.
REQ-025 DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-026 With out_ready held high, the time from timestep_start to done SHALL be exactly 3*NUM_NEURONS+1 cycles.
REQ-027 init_we SHALL be honoured only in IDLE and ignored otherwise; an address >= NUM_NEURONS SHALL be ignored.
REQ-028 If init_we and timestep_start occur together in IDLE, the write SHALL take effect first and the sweep SHALL read the new value.
REQ-029 Decay with rate codes 0001, 0010, 0100 and 1000 SHALL keep the sign and mantissa and subtract 0, 1, 2 or 3 respectively from the exponent.
REQ-030 Rate code 0011 (x*0.75) SHALL form s = {1,mantissa} (24 bits) and sum = s + (s>>1), truncating.
REQ-031 For rate code 0011, if sum < 2.0 the exponent SHALL be e-1 with mantissa sum[22:0].
REQ-032 For rate code 0011, if sum >= 2.0 the sum SHALL be shifted right by 1 (truncating) and the exponent kept at e.
REQ-033 Any other rate code SHALL behave as divide-by-1.
REQ-034 An input with e = 0 SHALL produce {sign,31'b0}.
REQ-035 If e <= k for shift k (1, 2, 3; 1 for code 0011), the result SHALL flush to {sign,31'b0}.
REQ-036 An input with e = 255 (Inf or NaN) SHALL pass through unchanged.

Reset
REQ-037 Reset SHALL load RESET_POTENTIAL and rate 4'b0001 into every entry and put the FSM in IDLE.
REQ-038 Reset SHALL drive out_valid, busy and done to 0, and out_addr and out_potential to 0.
REQ-039 Reset during a sweep SHALL abort it without a done pulse, and entries already written back SHALL still be reset.

Configuration
REQ-040 With macro POTENTIAL_DECAY_UNDERFLOW_CNT_EN defined, the block SHALL add a 16-bit output underflow_count.
REQ-041 underflow_count SHALL clear on timestep_start acceptance and saturate at 16'hFFFF.
REQ-042 underflow_count SHALL increment on each EMIT handshake whose result was flushed under REQ-035 (not REQ-034), and be 0 after reset.
REQ-043 Without POTENTIAL_DECAY_UNDERFLOW_CNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-044 Reset, rate 0010 at neuron 0, sweep -> out_addr 0 gives 32'h415ED852, done at cycle 3*32+1 = 97.
REQ-045 Rate 0011 with 32'h40800000 -> 32'h40400000; rate 0011 with 32'h40E00000 -> 32'h40A80000.
REQ-046 Rate 1000 with 32'h01800000 -> 32'h00000000; with 32'h81800000 -> 32'h80000000 (count +2 if enabled); 32'h7FC00000 -> unchanged.
REQ-047 out_ready low for 5 cycles at index 2 -> out_valid and data held stable, done delayed by exactly 5 cycles, each index emitted once.
REQ-048 timestep_start and init_we mid-sweep -> ignored; reset at index 10 -> no done, busy 0 next cycle, all entries back to 32'h41DED852.
